// File: rtl/urv_dm_arbiter_pkg.sv
// rtl/urv_dm_arbiter_pkg.sv - state and grant encodings shared by the data-memory arbiter
package urv_dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DBG  = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } gnt_t;

endpackage

// File: rtl/urv_dm_arbiter_if.sv
// rtl/urv_dm_arbiter_if.sv - single-outstanding data-memory bus between arbiter and memory
interface urv_dm_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, sel, input ack, rdata);
  modport slave  (input req, we, addr, wdata, sel, output ack, rdata);
endinterface

// File: rtl/urv_dm_arbiter_rr_arb2.sv
// rtl/urv_dm_arbiter_rr_arb2.sv - two-requester round-robin grant with last-grant memory
module urv_rr_arb2
  import urv_dm_arbiter_pkg::*;
#(
  parameter int g_cpu_first = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic cpu_ok,
  output logic gnt_cpu,
  output logic gnt_dbg
);

  gnt_t last_grant;

  // CPU may go unless debug is waiting and the CPU had the previous turn
  always_comb begin
    cpu_ok  = !(dbg_req && (last_grant == GNT_CPU));
    gnt_cpu = en && cpu_req && cpu_ok;
    gnt_dbg = en && dbg_req && !gnt_cpu;
  end

  // Remember who was served last so a contested arbitration alternates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= (g_cpu_first != 0) ? GNT_DBG : GNT_CPU;
    end else if (gnt_cpu) begin
      last_grant <= GNT_CPU;
    end else if (gnt_dbg) begin
      last_grant <= GNT_DBG;
    end
  end

endmodule

// File: rtl/urv_dm_arbiter.sv
// rtl/urv_dm_arbiter.sv - CPU/debug arbiter for the uRV data-memory port with optional timeout
module urv_dm_arbiter
  import urv_dm_arbiter_pkg::*;
#(
  parameter int g_timeout_cycles = 0,
  parameter int g_cpu_first      = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_s_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_load_i,
  input  logic        cpu_store_i,
  output logic        cpu_ready_o,
  output logic        cpu_load_done_o,
  output logic [31:0] cpu_data_l_o,
  output logic        cpu_err_o,
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [31:0] dbg_addr_i,
  input  logic [31:0] dbg_data_i,
  input  logic [3:0]  dbg_sel_i,
  output logic        dbg_ack_o,
  output logic [31:0] dbg_data_o,
  output logic        dbg_err_o,
  urv_dm_arbiter_if.master mem
);

  // Counter only needs to reach the limit; keep one bit when the timeout is disabled
  localparam int CW     = (g_timeout_cycles > 0) ? $clog2(g_timeout_cycles + 1) : 1;
  localparam int LIM_M1 = (g_timeout_cycles > 0) ? g_timeout_cycles - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = (g_timeout_cycles > 0) ? CW'(g_timeout_cycles) : '0;

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          idle, xfer, done, tmo;
  logic          cpu_ok, gnt_cpu, gnt_dbg;

  assign idle        = (state_q == ARB_IDLE);
  assign xfer        = !idle;
  assign done        = xfer && mem.ack;
  // The limit is hit on the cycle the counter would step onto g_timeout_cycles;
  // an ack in that same cycle wins and completes normally
  assign tmo         = (g_timeout_cycles > 0) && xfer && !mem.ack && (cnt_q == CW'(LIM_M1));
  assign cpu_ready_o = idle && cpu_ok;
  assign mem.req     = xfer;

  urv_rr_arb2 #(
    .g_cpu_first (g_cpu_first)
  ) u_rr (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .en      (idle),
    .cpu_req (cpu_load_i | cpu_store_i),
    .dbg_req (dbg_req_i),
    .cpu_ok  (cpu_ok),
    .gnt_cpu (gnt_cpu),
    .gnt_dbg (gnt_dbg)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next state: grant from IDLE, return on ack or timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_cpu)      state_d = ARB_CPU;
        else if (gnt_dbg) state_d = ARB_DBG;
      end
      ARB_CPU, ARB_DBG: begin
        if (done || tmo) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Wait counter: cleared on grant, saturating increment while waiting for ack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (gnt_cpu || gnt_dbg) begin
      cnt_q <= '0;
    end else if (xfer && !mem.ack && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Capture the winner's access onto the bus; held stable for the whole transfer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mem.we    <= 1'b0;
      mem.addr  <= '0;
      mem.wdata <= '0;
      mem.sel   <= '0;
    end else if (gnt_cpu) begin
      mem.we    <= cpu_store_i;
      mem.addr  <= cpu_addr_i;
      mem.wdata <= cpu_data_s_i;
      mem.sel   <= cpu_sel_i;
    end else if (gnt_dbg) begin
      mem.we    <= dbg_we_i;
      mem.addr  <= dbg_addr_i;
      mem.wdata <= dbg_data_i;
      mem.sel   <= dbg_sel_i;
    end
  end

  // Completion pulses and read data returned to the owning master
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpu_load_done_o <= 1'b0;
      cpu_err_o       <= 1'b0;
      cpu_data_l_o    <= '0;
      dbg_ack_o       <= 1'b0;
      dbg_err_o       <= 1'b0;
      dbg_data_o      <= '0;
    end else begin
      cpu_load_done_o <= (state_q == ARB_CPU) && done && !mem.we;
      cpu_err_o       <= (state_q == ARB_CPU) && tmo;
      dbg_ack_o       <= (state_q == ARB_DBG) && (done || tmo);
      dbg_err_o       <= (state_q == ARB_DBG) && tmo;
      if ((state_q == ARB_CPU) && done && !mem.we) cpu_data_l_o <= mem.rdata;
      if ((state_q == ARB_DBG) && done && !mem.we) dbg_data_o   <= mem.rdata;
    end
  end

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// tb/tb_urv_dm_arbiter.sv - self-checking bench for urv_dm_arbiter
module tb_urv_dm_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic        cpu_load = 1'b0, cpu_store = 1'b0;
  logic        cpu_ready, cpu_load_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic [3:0]  dbg_sel = '0;
  logic        dbg_ack, dbg_err;
  logic [31:0] dbg_rdata;

  urv_dm_arbiter_if mem_bus ();

  urv_dm_arbiter #(
    .g_timeout_cycles (TMO),
    .g_cpu_first      (1)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .cpu_addr_i      (cpu_addr),
    .cpu_data_s_i    (cpu_wdata),
    .cpu_sel_i       (cpu_sel),
    .cpu_load_i      (cpu_load),
    .cpu_store_i     (cpu_store),
    .cpu_ready_o     (cpu_ready),
    .cpu_load_done_o (cpu_load_done),
    .cpu_data_l_o    (cpu_rdata),
    .cpu_err_o       (cpu_err),
    .dbg_req_i       (dbg_req),
    .dbg_we_i        (dbg_we),
    .dbg_addr_i      (dbg_addr),
    .dbg_data_i      (dbg_wdata),
    .dbg_sel_i       (dbg_sel),
    .dbg_ack_o       (dbg_ack),
    .dbg_data_o      (dbg_rdata),
    .dbg_err_o       (dbg_err),
    .mem             (mem_bus.master)
  );

  always #5 clk = ~clk;

  typedef enum int {K_NONE, K_CPU_LOAD, K_CPU_ERR, K_DBG_ACK, K_DBG_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    bit          is_dbg;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          ack_delay;
    logic [31:0] rdata;
    kind_t       exp_kind;
    logic [31:0] exp_data;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: acks ack_delay cycles after req is first seen; 99 never acks
  int          ack_delay = 0;
  logic [31:0] rd_val = '0;
  int          wait_cnt = 0;
  bit          ack_sent = 0;
  initial begin
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_bus.req && !ack_sent) begin
        if (wait_cnt == ack_delay) begin
          mem_bus.ack   = 1'b1;
          mem_bus.rdata = rd_val;
          ack_sent      = 1;
        end else begin
          mem_bus.ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_bus.ack = 1'b0;
        if (!mem_bus.req) begin
          wait_cnt = 0;
          ack_sent = 0;
        end
      end
    end
  end

  // Scoreboard: every completion pulse pops the oldest expected completion
  initial begin : sb_mon
    kind_t       k;
    logic [31:0] d;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (cpu_load_done || cpu_err || dbg_ack) begin
        if (cpu_load_done)     k = K_CPU_LOAD;
        else if (cpu_err)      k = K_CPU_ERR;
        else if (dbg_err)      k = K_DBG_ERR;
        else                   k = K_DBG_ACK;
        d = (k == K_CPU_LOAD || k == K_CPU_ERR) ? cpu_rdata : dbg_rdata;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got kind %0d data %h with nothing pending", int'(k), d);
        end else begin
          e = sb_q.pop_front();
          check("sb_kind", int'(k), int'(e.kind));
          check("sb_data", d, e.data);
        end
      end
      if (dbg_err) check("dbg_err_with_ack", dbg_ack, 1'b1);
    end
  end

  // Bus monitor: fields stable while req is high, req length as modelled
  bit          mon_en = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_sel = '0;
  logic        exp_we = 1'b0;
  int          exp_req_len = 0;
  int          req_cycles = 0;
  bit          prev_req = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && mem_bus.req) begin
        req_cycles++;
        check("mem_addr", mem_bus.addr, exp_addr);
        check("mem_wdata", mem_bus.wdata, exp_wdata);
        check("mem_sel", mem_bus.sel, exp_sel);
        check("mem_we", mem_bus.we, exp_we);
      end
      if (mon_en && !mem_bus.req && prev_req) check("req_len", req_cycles, exp_req_len);
      if (!mem_bus.req) req_cycles = 0;
      prev_req = mem_bus.req;
    end
  end

  // CPU must never request while the arbiter is not ready
  always @(posedge clk) begin
    if (rst_n && (cpu_load || cpu_store) && !cpu_ready) begin
      bad++;
      $display("FAIL cpu_protocol: request while cpu_ready_o=0");
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cpu_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready: got timeout want cpu_ready_o=1");
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    ack_delay   = v.ack_delay;
    rd_val      = v.rdata;
    exp_addr    = v.addr;
    exp_wdata   = v.wdata;
    exp_sel     = v.sel;
    exp_we      = v.we;
    exp_req_len = (v.ack_delay < TMO) ? v.ack_delay + 1 : TMO;
    if (v.exp_kind != K_NONE) sb_q.push_back('{v.exp_kind, v.exp_data});
    n = 0;
    if (!v.is_dbg) begin
      wait_ready();
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      cpu_sel   = v.sel;
      cpu_load  = !v.we;
      cpu_store = v.we;
      @(posedge clk);
      #1;
      cpu_load  = 1'b0;
      cpu_store = 1'b0;
      @(negedge clk);
      while (mem_bus.req && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("cpu_req_dropped", mem_bus.req, 1'b0);
      check("cpu_ready_after_done", cpu_ready, 1'b1);
    end else begin
      dbg_we    = v.we;
      dbg_addr  = v.addr;
      dbg_wdata = v.wdata;
      dbg_sel   = v.sel;
      dbg_req   = 1'b1;
      @(negedge clk);
      while (!dbg_ack && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("dbg_ack_seen", dbg_ack, 1'b1);
      dbg_req = 1'b0;
    end
    @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin : main
    vecs[0] = '{0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 2,  32'h0,        K_NONE,     32'h0};
    vecs[1] = '{0, 0, 32'h104, 32'h0,        4'hF, 0,  32'h12345678, K_CPU_LOAD, 32'h12345678};
    vecs[2] = '{1, 0, 32'h200, 32'h0,        4'hF, 1,  32'hCAFEF00D, K_DBG_ACK,  32'hCAFEF00D};
    vecs[3] = '{1, 1, 32'h204, 32'h55AA55AA, 4'h3, 0,  32'hFFFFFFFF, K_DBG_ACK,  32'hCAFEF00D};
    vecs[4] = '{1, 0, 32'h300, 32'h0,        4'hF, 99, 32'h11111111, K_DBG_ERR,  32'hCAFEF00D};
    vecs[5] = '{0, 0, 32'h108, 32'h0,        4'h1, 3,  32'hA5A5A5A5, K_CPU_LOAD, 32'hA5A5A5A5};
    vecs[6] = '{0, 0, 32'h10C, 32'h0,        4'hF, 99, 32'h22222222, K_CPU_ERR,  32'hA5A5A5A5};
    vecs[7] = '{1, 0, 32'h400, 32'h0,        4'hC, 3,  32'h0BADBEEF, K_DBG_ACK,  32'h0BADBEEF};
    vecs[8] = '{0, 1, 32'h110, 32'h01020304, 4'hF, 99, 32'h0,        K_CPU_ERR,  32'hA5A5A5A5};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_bus.req, 1'b0);
    check("rst_mem_addr", mem_bus.addr, 32'h0);
    check("rst_cpu_done", cpu_load_done, 1'b0);
    check("rst_cpu_err", cpu_err, 1'b0);
    check("rst_cpu_data", cpu_rdata, 32'h0);
    check("rst_dbg_ack", dbg_ack, 1'b0);
    check("rst_dbg_data", dbg_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 1'b1);

    // Table of single accesses
    mon_en = 1;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    mon_en = 0;
    check("sb_empty_after_table", sb_q.size(), 0);

    // Reset in the middle of a CPU transfer
    ack_delay = 99;
    wait_ready();
    cpu_addr = 32'h700;
    cpu_sel  = 4'hF;
    cpu_load = 1'b1;
    @(posedge clk);
    #1 cpu_load = 1'b0;
    @(negedge clk);
    check("midrst_req_before", mem_bus.req, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req_async", mem_bus.req, 1'b0);
    check("midrst_no_done", cpu_load_done, 1'b0);
    check("midrst_no_err", cpu_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_ready_after", cpu_ready, 1'b1);
    check("midrst_req_after", mem_bus.req, 1'b0);

    // Contention straight after reset: CPU, debug, CPU, debug
    ack_delay = 0;
    rd_val    = 32'h11112222;
    sb_q.push_back('{K_CPU_LOAD, 32'h11112222});
    sb_q.push_back('{K_DBG_ACK, 32'h11112222});
    sb_q.push_back('{K_CPU_LOAD, 32'h11112222});
    sb_q.push_back('{K_DBG_ACK, 32'h11112222});
    check("cont_ready_first", cpu_ready, 1'b1);
    cpu_addr = 32'h500;
    cpu_load = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = 32'h600;
    dbg_req  = 1'b1;
    @(posedge clk);
    #1 cpu_load = 1'b0;
    @(negedge clk);
    check("cont_1_cpu_addr", mem_bus.addr, 32'h500);
    check("cont_1_ready_busy", cpu_ready, 1'b0);
    @(negedge clk);
    check("cont_dbg_owed_ready", cpu_ready, 1'b0);
    check("cont_idle_gap", mem_bus.req, 1'b0);
    @(negedge clk);
    check("cont_2_dbg_req", mem_bus.req, 1'b1);
    check("cont_2_dbg_addr", mem_bus.addr, 32'h600);
    @(negedge clk);
    check("cont_2_dbg_ack", dbg_ack, 1'b1);
    check("cont_cpu_turn_ready", cpu_ready, 1'b1);
    dbg_addr = 32'h604;
    cpu_addr = 32'h508;
    cpu_load = 1'b1;
    @(posedge clk);
    #1 cpu_load = 1'b0;
    @(negedge clk);
    check("cont_3_cpu_addr", mem_bus.addr, 32'h508);
    @(negedge clk);
    check("cont_3_dbg_owed", cpu_ready, 1'b0);
    @(negedge clk);
    check("cont_4_dbg_addr", mem_bus.addr, 32'h604);
    @(negedge clk);
    check("cont_4_dbg_ack", dbg_ack, 1'b1);
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_empty_final", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
